// File: rtl/draw_sprite.sv
// -----------------------------------------------------------------------------
// draw_sprite
// Parametrised sprite overlay stage for the VGA pixel pipeline. It addresses an
// external synchronous ROM, keys out a transparent colour and composites the
// sprite over the colour arriving from the previous stage. Position, mirroring
// and enable are captured once per frame on the rising edge of vblnk_in. A
// collision flag reports whether the previous frame drew an opaque sprite pixel
// over a non-background pixel.
//
// Ports:
//   pclk                      pixel clock
//   rst                       asynchronous active-low reset
//   hcount_in / vcount_in     pixel / line counters from the previous stage
//   hsync_in, vsync_in,
//   hblnk_in, vblnk_in        timing from the previous stage
//   rgb_in                    colour from the previous stage {r,g,b}
//   xpos / ypos               requested sprite top-left corner
//   mirror                    1 = horizontally flipped sprite
//   enable                    1 = sprite visible
//   pixel_addr                registered ROM address
//   rgb_pixel                 ROM data, valid one cycle after pixel_addr
//   hcount_out .. vblnk_out   counters and timing delayed by 3 cycles
//   rgb_out                   composited colour (3-cycle latency)
//   collide                   previous frame had a sprite/background overlap
// -----------------------------------------------------------------------------
module draw_sprite #(
    parameter int          SPR_W  = 128,
    parameter int          SPR_H  = 128,
    parameter int          ADDR_W = 14,
    parameter logic [11:0] TRANSP = 12'h0F0,
    parameter logic [11:0] BG_KEY = 12'h000
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [11:0]       hcount_in,
    input  logic [11:0]       vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hblnk_in,
    input  logic              vblnk_in,
    input  logic [11:0]       rgb_in,
    input  logic [11:0]       xpos,
    input  logic [11:0]       ypos,
    input  logic              mirror,
    input  logic              enable,
    output logic [ADDR_W-1:0] pixel_addr,
    input  logic [11:0]       rgb_pixel,
    output logic [11:0]       hcount_out,
    output logic [11:0]       vcount_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out,
    output logic [11:0]       rgb_out,
    output logic              collide
);

    // Frame-latched sprite attributes
    logic [11:0] r_x_l;
    logic [11:0] r_y_l;
    logic        r_mir_l;
    logic        r_en_l;
    logic        r_vblnk_prev;
    logic        r_hit_acc;

    // Stage 1 pipeline registers
    logic [11:0] r_hcount_d1;
    logic [11:0] r_vcount_d1;
    logic        r_hsync_d1;
    logic        r_vsync_d1;
    logic        r_hblnk_d1;
    logic        r_vblnk_d1;
    logic [11:0] r_rgb_d1;
    logic        r_win_d1;

    // Stage 2 pipeline registers
    logic [11:0] r_hcount_d2;
    logic [11:0] r_vcount_d2;
    logic        r_hsync_d2;
    logic        r_vsync_d2;
    logic        r_hblnk_d2;
    logic        r_vblnk_d2;
    logic [11:0] r_rgb_d2;
    logic        r_win_d2;

    logic              w_vrise;
    logic [12:0]       w_x_end;
    logic [12:0]       w_y_end;
    logic              w_in_win;
    logic [11:0]       w_col;
    logic [11:0]       w_row;
    logic [11:0]       w_colm;
    logic [ADDR_W-1:0] w_lin;
    logic              w_blank_d2;
    logic              w_spr_d2;
    logic              w_hit;

    assign w_vrise = vblnk_in & ~r_vblnk_prev;

    // Window ends are 13 bits wide so a sprite running past 4095 clips instead
    // of wrapping back to the left/top of the counter range.
    assign w_x_end = {1'b0, r_x_l} + 13'(SPR_W);
    assign w_y_end = {1'b0, r_y_l} + 13'(SPR_H);

    assign w_in_win = r_en_l
                    & ({1'b0, hcount_in} >= {1'b0, r_x_l})
                    & ({1'b0, hcount_in} <  w_x_end)
                    & ({1'b0, vcount_in} >= {1'b0, r_y_l})
                    & ({1'b0, vcount_in} <  w_y_end)
                    & ~hblnk_in & ~vblnk_in;

    assign w_col  = hcount_in - r_x_l;
    assign w_row  = vcount_in - r_y_l;
    assign w_colm = r_mir_l ? (12'(SPR_W - 1) - w_col) : w_col;

    // Computed directly at ROM-address width: modular arithmetic gives the
    // same result as a wide product truncated to ADDR_W bits.
    assign w_lin = ADDR_W'(w_row) * ADDR_W'(SPR_W) + ADDR_W'(w_colm);

    assign w_blank_d2 = r_hblnk_d2 | r_vblnk_d2;
    assign w_spr_d2   = r_win_d2 & (rgb_pixel != TRANSP);
    assign w_hit      = ~w_blank_d2 & w_spr_d2 & (r_rgb_d2 != BG_KEY);

    // Capture sprite attributes once per frame on the vblnk rising edge
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_vblnk_prev <= 1'b0;
            r_x_l        <= 12'd0;
            r_y_l        <= 12'd0;
            r_mir_l      <= 1'b0;
            r_en_l       <= 1'b0;
        end else begin
            r_vblnk_prev <= vblnk_in;
            if (w_vrise) begin
                r_x_l   <= xpos;
                r_y_l   <= ypos;
                r_mir_l <= mirror;
                r_en_l  <= enable;
            end
        end
    end

    // Stage 1: ROM address generation and first timing delay
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            pixel_addr  <= {ADDR_W{1'b0}};
            r_hcount_d1 <= 12'd0;
            r_vcount_d1 <= 12'd0;
            r_hsync_d1  <= 1'b0;
            r_vsync_d1  <= 1'b0;
            r_hblnk_d1  <= 1'b0;
            r_vblnk_d1  <= 1'b0;
            r_rgb_d1    <= 12'd0;
            r_win_d1    <= 1'b0;
        end else begin
            if (w_in_win) begin
                pixel_addr <= w_lin;
            end
            r_hcount_d1 <= hcount_in;
            r_vcount_d1 <= vcount_in;
            r_hsync_d1  <= hsync_in;
            r_vsync_d1  <= vsync_in;
            r_hblnk_d1  <= hblnk_in;
            r_vblnk_d1  <= vblnk_in;
            r_rgb_d1    <= rgb_in;
            r_win_d1    <= w_in_win;
        end
    end

    // Stage 2: second delay while the ROM returns data for the d1 address
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_hcount_d2 <= 12'd0;
            r_vcount_d2 <= 12'd0;
            r_hsync_d2  <= 1'b0;
            r_vsync_d2  <= 1'b0;
            r_hblnk_d2  <= 1'b0;
            r_vblnk_d2  <= 1'b0;
            r_rgb_d2    <= 12'd0;
            r_win_d2    <= 1'b0;
        end else begin
            r_hcount_d2 <= r_hcount_d1;
            r_vcount_d2 <= r_vcount_d1;
            r_hsync_d2  <= r_hsync_d1;
            r_vsync_d2  <= r_vsync_d1;
            r_hblnk_d2  <= r_hblnk_d1;
            r_vblnk_d2  <= r_vblnk_d1;
            r_rgb_d2    <= r_rgb_d1;
            r_win_d2    <= r_win_d1;
        end
    end

    // Output stage: composite sprite over background, blank outside active video
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hcount_out <= 12'd0;
            vcount_out <= 12'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'd0;
        end else begin
            hcount_out <= r_hcount_d2;
            vcount_out <= r_vcount_d2;
            hsync_out  <= r_hsync_d2;
            vsync_out  <= r_vsync_d2;
            hblnk_out  <= r_hblnk_d2;
            vblnk_out  <= r_vblnk_d2;
            if (w_blank_d2) begin
                rgb_out <= 12'd0;
            end else if (w_spr_d2) begin
                rgb_out <= rgb_pixel;
            end else begin
                rgb_out <= r_rgb_d2;
            end
        end
    end

    // Collision accumulator; published and cleared on each vblnk rise
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_hit_acc <= 1'b0;
            collide   <= 1'b0;
        end else begin
            if (w_vrise) begin
                collide   <= r_hit_acc | w_hit;
                r_hit_acc <= 1'b0;
            end else if (w_hit) begin
                r_hit_acc <= 1'b1;
            end else begin
                r_hit_acc <= r_hit_acc;
            end
        end
    end

endmodule

// File: tb/tb_draw_sprite.sv
// -----------------------------------------------------------------------------
// tb_draw_sprite
// Directed self-checking bench for draw_sprite with default parameters
// (128x128 sprite, 14-bit ROM address). A synchronous ROM model returns
// {1'b1, addr[10:0]} except for sprite column 5 (addr[6:0]==5), which returns
// the transparent colour 12'h0F0.
// -----------------------------------------------------------------------------
module tb_draw_sprite;

    logic        pclk;
    logic        rst;
    logic [11:0] hcount_in;
    logic [11:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        mirror;
    logic        enable;
    logic [13:0] pixel_addr;
    logic [11:0] rgb_pixel;
    logic [11:0] hcount_out;
    logic [11:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;
    logic        collide;

    int n_cmp;
    int n_err;

    draw_sprite dut (
        .pclk       (pclk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .mirror     (mirror),
        .enable     (enable),
        .pixel_addr (pixel_addr),
        .rgb_pixel  (rgb_pixel),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out),
        .collide    (collide)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    function automatic logic [11:0] rom_f(input logic [13:0] a);
        if (a[6:0] == 7'd5) begin
            return 12'h0F0;
        end else begin
            return {1'b1, a[10:0]};
        end
    endfunction

    // Synchronous sprite ROM model
    always_ff @(posedge pclk) begin
        rgb_pixel <= rom_f(pixel_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pixel clock with the given inputs; returns 1 time unit after the edge
    task automatic apply(input logic [11:0] h, input logic [11:0] v,
                         input logic hb, input logic vb, input logic [11:0] rgb);
        hcount_in = h;
        vcount_in = v;
        hblnk_in  = hb;
        vblnk_in  = vb;
        hsync_in  = h[0];
        vsync_in  = v[0];
        rgb_in    = rgb;
        @(posedge pclk);
        #1;
    endtask

    task automatic idle();
        apply(12'd0, 12'd0, 1'b1, 1'b0, 12'h000);
    endtask

    // Two blanked cycles so the pixel applied before reaches the outputs
    task automatic flush();
        idle();
        idle();
    endtask

    task automatic vrise();
        apply(12'd0, 12'd0, 1'b1, 1'b1, 12'h000);
        idle();
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        hcount_in = 12'd0;
        vcount_in = 12'd0;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        hblnk_in  = 1'b0;
        vblnk_in  = 1'b0;
        rgb_in    = 12'h000;
        xpos      = 12'd100;
        ypos      = 12'd200;
        mirror    = 1'b0;
        enable    = 1'b1;

        // Power-on reset
        #2 rst = 1'b0;
        #1;
        check_eq("por_rgb", 32'(rgb_out), 32'h0);
        check_eq("por_addr", 32'(pixel_addr), 32'h0);
        check_eq("por_collide", 32'(collide), 32'h0);
        check_eq("por_hcount", 32'(hcount_out), 32'h0);
        #1 rst = 1'b1;

        // Placement at x=100, y=200
        vrise();
        check_eq("coll_first", 32'(collide), 32'h0);
        apply(12'd100, 12'd200, 1'b0, 1'b0, 12'h000);
        check_eq("addr_topleft", 32'(pixel_addr), 32'd0);
        flush();
        check_eq("rgb_topleft", 32'(rgb_out), 32'h800);
        check_eq("hcnt_topleft", 32'(hcount_out), 32'd100);
        apply(12'd227, 12'd327, 1'b0, 1'b0, 12'h000);
        check_eq("addr_botright", 32'(pixel_addr), 32'd16383);
        flush();
        check_eq("rgb_botright", 32'(rgb_out), 32'hFFF);
        check_eq("vcnt_botright", 32'(vcount_out), 32'd327);
        check_eq("hsync_botright", 32'(hsync_out), 32'h1);
        apply(12'd99, 12'd200, 1'b0, 1'b0, 12'h123);
        check_eq("addr_hold", 32'(pixel_addr), 32'd16383);
        flush();
        check_eq("rgb_left_out", 32'(rgb_out), 32'h123);
        apply(12'd228, 12'd327, 1'b0, 1'b0, 12'h456);
        flush();
        check_eq("rgb_right_out", 32'(rgb_out), 32'h456);
        apply(12'd100, 12'd328, 1'b0, 1'b0, 12'h789);
        flush();
        check_eq("rgb_below_out", 32'(rgb_out), 32'h789);
        apply(12'd105, 12'd201, 1'b0, 1'b0, 12'h321);
        check_eq("addr_col5", 32'(pixel_addr), 32'd133);
        flush();
        check_eq("rgb_transp", 32'(rgb_out), 32'h321);
        apply(12'd110, 12'd210, 1'b0, 1'b0, 12'h000);
        check_eq("addr_mid", 32'(pixel_addr), 32'd1290);
        flush();
        check_eq("rgb_mid", 32'(rgb_out), 32'hD0A);
        apply(12'd110, 12'd210, 1'b1, 1'b0, 12'h555);
        flush();
        check_eq("rgb_hblank", 32'(rgb_out), 32'h000);

        // Mirror takes effect only after the next vblnk rise
        mirror = 1'b1;
        apply(12'd100, 12'd200, 1'b0, 1'b0, 12'h000);
        check_eq("addr_mir_pending", 32'(pixel_addr), 32'd0);
        flush();
        vrise();
        check_eq("coll_clean", 32'(collide), 32'h0);
        apply(12'd100, 12'd200, 1'b0, 1'b0, 12'h000);
        check_eq("addr_mir_left", 32'(pixel_addr), 32'd127);
        flush();
        check_eq("rgb_mir_left", 32'(rgb_out), 32'h87F);
        apply(12'd227, 12'd200, 1'b0, 1'b0, 12'h000);
        check_eq("addr_mir_right", 32'(pixel_addr), 32'd0);
        flush();
        check_eq("rgb_mir_right", 32'(rgb_out), 32'h800);
        apply(12'd222, 12'd200, 1'b0, 1'b0, 12'h0E0);
        check_eq("addr_mir_col5", 32'(pixel_addr), 32'd5);
        flush();
        check_eq("rgb_mir_transp", 32'(rgb_out), 32'h0E0);

        // Position change mid-frame waits for the next vblnk rise
        mirror = 1'b0;
        vrise();
        xpos = 12'd300;
        apply(12'd100, 12'd200, 1'b0, 1'b0, 12'h000);
        flush();
        check_eq("rgb_old_pos", 32'(rgb_out), 32'h800);
        apply(12'd300, 12'd200, 1'b0, 1'b0, 12'h222);
        flush();
        check_eq("rgb_new_pending", 32'(rgb_out), 32'h222);
        vrise();
        apply(12'd300, 12'd200, 1'b0, 1'b0, 12'h000);
        flush();
        check_eq("rgb_new_pos", 32'(rgb_out), 32'h800);
        apply(12'd100, 12'd200, 1'b0, 1'b0, 12'h333);
        flush();
        check_eq("rgb_old_gone", 32'(rgb_out), 32'h333);

        // Collision: opaque sprite over non-background pixel
        apply(12'd300, 12'd200, 1'b0, 1'b0, 12'h00F);
        flush();
        check_eq("rgb_hit", 32'(rgb_out), 32'h800);
        check_eq("coll_before_rise", 32'(collide), 32'h0);
        vrise();
        check_eq("coll_set", 32'(collide), 32'h1);
        apply(12'd300, 12'd200, 1'b0, 1'b0, 12'h000);
        flush();
        check_eq("coll_held", 32'(collide), 32'h1);
        vrise();
        check_eq("coll_clear", 32'(collide), 32'h0);

        // Disabled sprite is a pure pass-through
        enable = 1'b0;
        vrise();
        apply(12'd300, 12'd200, 1'b0, 1'b0, 12'h00F);
        flush();
        check_eq("rgb_disabled", 32'(rgb_out), 32'h00F);
        vrise();
        check_eq("coll_disabled", 32'(collide), 32'h0);

        // Sprite overrunning 4095 clips instead of wrapping
        enable = 1'b1;
        xpos   = 12'd4000;
        vrise();
        apply(12'd4095, 12'd200, 1'b0, 1'b0, 12'h00F);
        check_eq("addr_clip", 32'(pixel_addr), 32'd95);
        flush();
        check_eq("rgb_clip", 32'(rgb_out), 32'h85F);
        apply(12'd0, 12'd200, 1'b0, 1'b0, 12'h0CD);
        flush();
        check_eq("rgb_nowrap", 32'(rgb_out), 32'h0CD);
        vrise();
        check_eq("coll_clip", 32'(collide), 32'h1);

        // Asynchronous reset mid-line
        apply(12'd51, 12'd11, 1'b0, 1'b0, 12'hABC);
        apply(12'd51, 12'd11, 1'b0, 1'b0, 12'hABC);
        apply(12'd51, 12'd11, 1'b0, 1'b0, 12'hABC);
        check_eq("rgb_pre_rst", 32'(rgb_out), 32'hABC);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_rgb", 32'(rgb_out), 32'h0);
        check_eq("rst_addr", 32'(pixel_addr), 32'h0);
        check_eq("rst_collide", 32'(collide), 32'h0);
        check_eq("rst_hcount", 32'(hcount_out), 32'h0);
        check_eq("rst_hsync", 32'(hsync_out), 32'h0);
        check_eq("rst_vsync", 32'(vsync_out), 32'h0);
        #1 rst = 1'b1;

        // Sprite hidden until the first vblnk rise after reset
        xpos = 12'd100;
        ypos = 12'd100;
        apply(12'd100, 12'd100, 1'b0, 1'b0, 12'h00F);
        check_eq("addr_post_rst", 32'(pixel_addr), 32'h0);
        flush();
        check_eq("rgb_post_rst", 32'(rgb_out), 32'h00F);
        vrise();
        apply(12'd100, 12'd100, 1'b0, 1'b0, 12'h000);
        flush();
        check_eq("rgb_after_rise", 32'(rgb_out), 32'h800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/draw_sprite.md
Name: draw_sprite

Overview:
Generic parametrised sprite overlay stage for the VGA pixel pipeline, replacing the fixed-size player drawer. It sits between draw_background (or another overlay stage) and the VGA outputs. It fetches sprite pixels from an external synchronous ROM and keys out a transparent colour. Position, mirroring and enable are latched once per frame, and the block reports a per-frame collision flag.

Parameters:
SPR_W, 128, sprite width in pixels (power of two not required)
SPR_H, 128, sprite height in pixels
ADDR_W, 14, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H
TRANSP, 12'h0F0, sprite RGB value treated as transparent
BG_KEY, 12'h000, rgb_in value treated as "empty" for collision detection

Ports:
pclk  in  1  pixel clock (65 MHz)
rst  in  1  asynchronous, active-low reset
hcount_in  in  12  horizontal pixel counter
vcount_in  in  12  vertical line counter
hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing from previous stage
rgb_in  in  12  pixel colour from previous stage {r,g,b}
xpos  in  12  requested sprite left edge (screen x)
ypos  in  12  requested sprite top edge (screen y)
mirror  in  1  1 = draw horizontally flipped
enable  in  1  1 = sprite visible
pixel_addr  out  ADDR_W  ROM address (registered)
rgb_pixel  in  12  ROM data, valid 1 cycle after pixel_addr
hcount_out, vcount_out  out  12 each  delayed counters
hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing
rgb_out  out  12  composited colour
collide  out  1  previous frame had an opaque sprite pixel over non-BG_KEY background

Behaviour:
- Reset (rst low, asynchronous): every output is 0 (pixel_addr, timing, counters, rgb_out, collide). Latched x/y/mirror/enable are 0, the vblnk edge register is 0 and the collision accumulator is 0.
- Frame latch: vblnk_prev is registered every cycle. On the cycle where vblnk_in=1 and vblnk_prev=0, xpos/ypos/mirror/enable are captured into x_l/y_l/mir_l/en_l. Input changes at any other time have no effect until the next vblnk rise.
- Stage 1 (cycle after input):
  - Compute in-window as: en_l & hcount_in >= x_l & hcount_in < x_l+SPR_W & vcount_in >= y_l & vcount_in < y_l+SPR_H & !hblnk_in & !vblnk_in.
  - Sums use 13-bit arithmetic, so a sprite overrunning 4095 clips and never wraps.
  - col = hcount_in - x_l; row = vcount_in - y_l.
  - colm = mir_l ? SPR_W-1-col : col.
  - pixel_addr <= row*SPR_W + colm, truncated to ADDR_W. Outside the window, pixel_addr holds its last value.
  - All timing, counters, rgb_in and in-window are registered (d1).
- Stage 2: the ROM returns rgb_pixel for the d1 address. Timing, counters, rgb_in and in-window are registered again (d2).
- Output: rgb_out is registered the same cycle from d2 values:
  - blanking (hblnk_d2 | vblnk_d2): rgb_out = 0
  - else in-window_d2 & rgb_pixel != TRANSP: rgb_out = rgb_pixel
  - else: rgb_out = rgb_in_d2
- Latency: fixed 3 pclk from inputs to all outputs. Timing outputs are delayed identically so alignment is preserved. Chained instances add 3 cycles each.
- Collision:
  - hit_acc is set on any cycle where rgb_out is sourced from the sprite and rgb_in_d2 != BG_KEY.
  - On the vblnk rise cycle: collide <= hit_acc (or hit in that same cycle) and hit_acc <= 0. collide is held for a full frame.
- Boundaries:
  - x_l+SPR_W > 1024 gives a visible partial sprite. x_l >= 1024 or y_l >= 768 gives no pixels drawn.
  - en_l=0 gives a pass-through with 3-cycle delay, and collide becomes 0 after the next vblnk rise.
  - Reset mid-frame: outputs go to 0 immediately. The sprite stays hidden until the first vblnk rise after reset release, because en_l=0.

Test Plan:
- Reset: drive rst low mid-line -> all outputs 0 asynchronously. After release with enable=1 and xpos=100, ypos=100: no sprite pixel appears before the first vblnk rise.
- Placement/latency: SPR_W=SPR_H=128, x=100, y=200, enable=1, ROM data = address LSBs. At hcount_in=100, vcount_in=200, pixel_addr=0 one cycle later. At hcount_in=227, vcount_in=327, pixel_addr=16383. rgb_out matches the ROM 3 cycles after hcount input; hcount 99 and 228 pass rgb_in through.
- Mirror: mirror=1, x=100. At hcount_in=100, vcount_in=200 -> pixel_addr=127; at hcount_in=227 -> pixel_addr=0.
- Transparency/blanking: ROM returns 12'h0F0 for column 5 -> rgb_out = rgb_in there. Sprite overlapping hblnk -> rgb_out=0.
- Frame latch: change xpos from 100 to 300 mid-frame -> sprite stays at 100 until after the next vblnk rise, then appears at 300.
- Collision: rgb_in=12'h00F under an opaque sprite region -> collide=1 from the next vblnk rise for one frame. With rgb_in=BG_KEY everywhere, the next frame gives collide=0.
